// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared defaults and FSM state encoding for the UART transmit scheduler
package uart_pkg;

    localparam int NUM_REQ_DEF      = 4;
    localparam int DATA_W_DEF       = 8;
    localparam int BUSY_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin one-hot select starting at a pointer
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    int   idx;
    logic found;

    // Scan requesters from ptr upward, wrapping, and pick the first one asserting req.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler feeding several byte requesters into one uart_send
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                      sys_clk,
    input  logic                      sys_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [DATA_W-1:0]         o_send_data,
    output logic                      o_send_data_en,
    input  logic                      i_uart_busy,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] IDLE      = ST_IDLE;
    localparam logic [1:0] ISSUE     = ST_ISSUE;
    localparam logic [1:0] WAIT_BUSY = ST_WAIT_BUSY;
    localparam logic [1:0] WAIT_DONE = ST_WAIT_DONE;

    logic [1:0]         state;
    logic               lock;
    logic               last_q;
    logic               timeout_q;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   busy_cnt;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] sel;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic [PTR_W-1:0]   sel_idx;
    logic               transfer;

    // While a packet is open only its owner may compete; the held grant doubles as the owner mask.
    always_comb begin
        eligible = lock ? (i_req_valid & grant_q) : i_req_valid;
    end

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (sel)
    );

    // Offer ready only to the selected requester, and only when the transmitter is free.
    always_comb begin
        if (state == IDLE && !i_uart_busy && !sys_reset) begin
            o_req_ready = sel;
        end else begin
            o_req_ready = '0;
        end
    end

    // Extract index, byte and last flag of the selected requester.
    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel[k]) begin
                sel_idx  = PTR_W'(k);
                sel_data = i_req_data[k*DATA_W +: DATA_W];
                sel_last = i_req_last[k];
            end
        end
    end

    // A byte moves when the selected requester still holds valid in the ready cycle.
    always_comb begin
        transfer = |(o_req_ready & i_req_valid);
        next_ptr = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
    end

    // Main sequencing: accept, strobe the transmitter, wait for busy to rise then fall.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state     <= IDLE;
            lock      <= 1'b0;
            last_q    <= 1'b0;
            timeout_q <= 1'b0;
            rr_ptr    <= '0;
            owner_idx <= '0;
            busy_cnt  <= '0;
            grant_q   <= '0;
            data_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        data_q    <= sel_data;
                        last_q    <= sel_last;
                        grant_q   <= sel;
                        owner_idx <= sel_idx;
                        if (!sel_last) begin
                            lock <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    busy_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= WAIT_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!i_uart_busy) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                        if (last_q) begin
                            lock    <= 1'b0;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The send strobe is exactly the one ISSUE cycle following a transfer.
    always_comb begin
        o_send_data_en = (state == ISSUE);
        o_send_data    = data_q;
        o_grant        = grant_q;
        o_timeout_err  = timeout_q;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BT = 16;

    logic             sys_clk = 1'b0;
    logic             sys_reset = 1'b1;
    logic [NR-1:0]    i_req_valid = '0;
    logic [NR*DW-1:0] i_req_data = '0;
    logic [NR-1:0]    i_req_last = '0;
    logic [NR-1:0]    o_req_ready;
    logic [DW-1:0]    o_send_data;
    logic             o_send_data_en;
    logic             i_uart_busy = 1'b0;
    logic [NR-1:0]    o_grant;
    logic             o_timeout_err;

    uart_tx_scheduler #(
        .NUM_REQ      (NR),
        .DATA_W       (DW),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .i_req_valid    (i_req_valid),
        .i_req_data     (i_req_data),
        .i_req_last     (i_req_last),
        .o_req_ready    (o_req_ready),
        .o_send_data    (o_send_data),
        .o_send_data_en (o_send_data_en),
        .i_uart_busy    (i_uart_busy),
        .o_grant        (o_grant),
        .o_timeout_err  (o_timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] grant;
    } exp_t;

    typedef struct {
        int         pre;
        logic [3:0] mask;
        logic [7:0] base;
        int         n;
        logic [7:0] ord;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    exp_t       sb[$];
    exp_t       sb_e;
    logic [8:0] src_q[NR][$];
    logic [3:0] hs;
    logic       en_seen;
    int         busy_cnt = 0;
    int         busy_len = 3;
    bit         suppress_busy = 1'b0;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < NR; k++) s += src_q[k].size();
        return s;
    endfunction

    // Requester sources, uart_send busy model and send scoreboard.
    initial begin : model
        forever begin
            @(negedge sys_clk);
            hs = i_req_valid & o_req_ready;
            if (sys_reset) hs = '0;
            en_seen = o_send_data_en;
            if (en_seen) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_send: got data %0h grant %0h, expected no send", o_send_data, o_grant);
                end else begin
                    sb_e = sb.pop_front();
                    check("send_data", 32'(o_send_data), 32'(sb_e.data));
                    check("send_grant", 32'(o_grant), 32'(sb_e.grant));
                end
                check("send_while_busy", 32'(i_uart_busy), 32'h0);
            end
            @(posedge sys_clk);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            end
            if (busy_cnt > 0) busy_cnt--;
            if (en_seen && !suppress_busy) busy_cnt = busy_len;
            i_uart_busy = (busy_cnt > 0);
            for (int k = 0; k < NR; k++) begin
                if (src_q[k].size() > 0) begin
                    i_req_valid[k]          = 1'b1;
                    i_req_data[k*DW +: DW]  = src_q[k][0][7:0];
                    i_req_last[k]           = src_q[k][0][8];
                end else begin
                    i_req_valid[k]          = 1'b0;
                    i_req_data[k*DW +: DW]  = '0;
                    i_req_last[k]           = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge sys_clk);
        #1;
        sys_reset = 1'b1;
        for (int k = 0; k < NR; k++) src_q[k].delete();
        sb.delete();
        busy_cnt      = 0;
        suppress_busy = 1'b0;
        busy_len      = 3;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_reset = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || pending() != 0 || i_uart_busy || o_grant != '0) && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        tests++;
        if (n >= 400) begin
            fails++;
            $display("FAIL %s: drain timeout, got %0d bytes outstanding, expected 0", name, sb.size() + pending());
        end
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int r0_ready;

        vecs[0] = '{pre: -1, mask: 4'b1111, base: 8'h10, n: 4, ord: 8'b11_10_01_00};
        vecs[1] = '{pre:  1, mask: 4'b1111, base: 8'h20, n: 4, ord: 8'b01_00_11_10};
        vecs[2] = '{pre:  2, mask: 4'b0101, base: 8'h30, n: 2, ord: 8'b00_00_10_00};
        vecs[3] = '{pre:  3, mask: 4'b0110, base: 8'h40, n: 2, ord: 8'b00_00_10_01};
        vecs[4] = '{pre: -1, mask: 4'b1010, base: 8'h50, n: 2, ord: 8'b00_00_11_01};
        vecs[5] = '{pre:  0, mask: 4'b1001, base: 8'h60, n: 2, ord: 8'b00_00_00_11};

        // reset values
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_ready", 32'(o_req_ready), 32'h0);
        check("rst_data", 32'(o_send_data), 32'h0);
        check("rst_en", 32'(o_send_data_en), 32'h0);
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_timeout", 32'(o_timeout_err), 32'h0);
        do_reset();

        // single requester 1 sends 0x5A
        src_q[1].push_back({1'b1, 8'h5A});
        sb.push_back('{data: 8'h5A, grant: 4'b0010});
        n = 0;
        @(negedge sys_clk);
        while (o_req_ready == '0 && n < 20) begin @(negedge sys_clk); n++; end
        check("t34_ready", 32'(o_req_ready), 32'h2);
        @(negedge sys_clk);
        check("t34_ready_1cyc", 32'(o_req_ready), 32'h0);
        check("t34_en", 32'(o_send_data_en), 32'h1);
        check("t34_data", 32'(o_send_data), 32'h5A);
        @(negedge sys_clk);
        check("t34_en_once", 32'(o_send_data_en), 32'h0);
        check("t34_grant_busy", 32'(o_grant), 32'h2);
        n = 0;
        while (i_uart_busy && n < 20) begin @(negedge sys_clk); n++; end
        check("t34_grant_done", 32'(o_grant), 32'h2);
        @(negedge sys_clk);
        check("t34_grant_idle", 32'(o_grant), 32'h0);
        wait_idle("t34");

        // table: pointer preset by an earlier owner, then a mask of simultaneous requesters
        for (int v = 0; v < 6; v++) begin
            do_reset();
            if (vecs[v].pre >= 0) begin
                src_q[vecs[v].pre].push_back({1'b1, 8'hF0 + 8'(vecs[v].pre)});
                sb.push_back('{data: 8'hF0 + 8'(vecs[v].pre), grant: 4'(1 << vecs[v].pre)});
                wait_idle("vec_pre");
            end
            for (int k = 0; k < NR; k++) begin
                if (vecs[v].mask[k]) src_q[k].push_back({1'b1, vecs[v].base + 8'(k)});
            end
            for (int i = 0; i < vecs[v].n; i++) begin
                logic [1:0] o;
                o = vecs[v].ord[2*i +: 2];
                sb.push_back('{data: vecs[v].base + 8'(o), grant: 4'(1 << o)});
            end
            wait_idle("vec_order");
        end

        // lock: requester 2 packet A1,A2 completes before requester 0
        do_reset();
        src_q[2].push_back({1'b0, 8'hA1});
        sb.push_back('{data: 8'hA1, grant: 4'b0100});
        sb.push_back('{data: 8'hA2, grant: 4'b0100});
        sb.push_back('{data: 8'h33, grant: 4'b0001});
        n = 0;
        while (!o_req_ready[2] && n < 20) begin @(negedge sys_clk); n++; end
        check("t36_a1_ready", 32'(o_req_ready), 32'h4);
        src_q[0].push_back({1'b1, 8'h33});
        r0_ready = 0;
        repeat (12) begin
            @(negedge sys_clk);
            if (o_req_ready != '0) r0_ready++;
        end
        check("t36_others_blocked", 32'(r0_ready), 32'h0);
        check("t36_grant_locked", 32'(o_grant), 32'h4);
        src_q[2].push_back({1'b1, 8'hA2});
        wait_idle("t36");

        // busy never rises: timeout pulse, then recovery
        do_reset();
        suppress_busy = 1'b1;
        src_q[3].push_back({1'b1, 8'h77});
        sb.push_back('{data: 8'h77, grant: 4'b1000});
        n = 0;
        while (!o_send_data_en && n < 30) begin @(negedge sys_clk); n++; end
        check("t37_send", 32'(o_send_data_en), 32'h1);
        n = 0;
        while (!o_timeout_err && n < 40) begin @(negedge sys_clk); n++; end
        check("t37_timeout_latency", 32'(n), 32'd17);
        @(negedge sys_clk);
        check("t37_pulse_width", 32'(o_timeout_err), 32'h0);
        suppress_busy = 1'b0;
        src_q[1].push_back({1'b1, 8'h88});
        sb.push_back('{data: 8'h88, grant: 4'b0010});
        wait_idle("t37_next");

        // reset during WAIT_DONE with lock held
        do_reset();
        src_q[2].push_back({1'b1, 8'hB2});
        sb.push_back('{data: 8'hB2, grant: 4'b0100});
        wait_idle("t38_pre");
        busy_len = 10;
        src_q[1].push_back({1'b0, 8'hC1});
        sb.push_back('{data: 8'hC1, grant: 4'b0010});
        n = 0;
        while (!i_uart_busy && n < 20) begin @(negedge sys_clk); n++; end
        repeat (2) @(negedge sys_clk);
        check("t38_grant_before", 32'(o_grant), 32'h2);
        @(posedge sys_clk);
        #1;
        sys_reset = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_reset = 1'b0;
        @(negedge sys_clk);
        check("t38_ready", 32'(o_req_ready), 32'h0);
        check("t38_data", 32'(o_send_data), 32'h0);
        check("t38_en", 32'(o_send_data_en), 32'h0);
        check("t38_grant", 32'(o_grant), 32'h0);
        check("t38_timeout", 32'(o_timeout_err), 32'h0);
        busy_len = 3;
        src_q[0].push_back({1'b1, 8'hE0});
        src_q[3].push_back({1'b1, 8'hD3});
        sb.push_back('{data: 8'hE0, grant: 4'b0001});
        sb.push_back('{data: 8'hD3, grant: 4'b1000});
        r0_ready = 0;
        n = 0;
        while (i_uart_busy && n < 30) begin
            @(negedge sys_clk);
            if (i_uart_busy && o_req_ready != '0) r0_ready++;
            n++;
        end
        check("t38_busy_blocks", 32'(r0_ready), 32'h0);
        wait_idle("t38_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one uart_send transmitter (range 2..8).
REQ-002 Parameter DATA_W, default 8, byte width per request.
REQ-003 Parameter BUSY_TIMEOUT, default 16, cycles to wait for i_uart_busy to rise after a send pulse.
REQ-004 sys_clk  input  1  single clock; same clock as the driven uart_send.
REQ-005 sys_reset  input  1  synchronous, active-high reset.
REQ-006 i_req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 i_req_data  input  NUM_REQ*DATA_W  per-requester byte; requester k at bits [k*DATA_W +: DATA_W].
REQ-008 i_req_last  input  NUM_REQ  per-requester last-byte-of-packet flag, qualified by valid.
REQ-009 o_req_ready  output  NUM_REQ  per-requester accept; a byte transfers on valid&ready in the same cycle.
REQ-010 o_send_data  output  DATA_W  byte to uart_send i_send_data.
REQ-011 o_send_data_en  output  1  one-cycle send strobe to uart_send i_send_data_en.
REQ-012 i_uart_busy  input  1  uart_send busy flag.
REQ-013 o_grant  output  NUM_REQ  one-hot owner of the transmitter; zero when idle.
REQ-014 o_timeout_err  output  1  one-cycle pulse when busy failed to rise within BUSY_TIMEOUT.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: when i_uart_busy=0 and a requester is eligible, o_req_ready of exactly the selected requester is 1 (combinational); otherwise all ready bits are 0.
REQ-017 Selection: round-robin, search starts at (last owner+1) mod NUM_REQ; after reset the search starts at requester 0.
REQ-018 When locked (REQ-024), only the lock owner is eligible.
REQ-019 On transfer: latch data into o_send_data, latch last flag, set o_grant to the owner, go to ISSUE.
REQ-020 ISSUE: o_send_data_en=1 for exactly one cycle (one cycle after the transfer), go to WAIT_BUSY; o_send_data is stable from ISSUE until the next transfer.
REQ-021 WAIT_BUSY: i_uart_busy=1 -> WAIT_DONE; counter reaching BUSY_TIMEOUT with busy still 0 -> o_timeout_err pulse, go to WAIT_DONE.
REQ-022 WAIT_DONE: i_uart_busy=0 -> IDLE; the round-robin pointer updates to the owner.
REQ-023 o_grant clears on entering IDLE unless locked.
REQ-024 Lock: a transferred byte with last=0 locks the grant to its owner; a byte with last=1 clears the lock on return to IDLE.
REQ-025 While locked, other requesters are never served, even if the owner drops valid.
REQ-026 In any state other than IDLE, all o_req_ready bits are 0; at most one byte is in flight.
REQ-027 i_uart_busy=1 in IDLE (e.g. after an external reset release) blocks acceptance until it falls.
REQ-028 Simultaneous valid on all requesters with last=1: bytes are served in rotating order 0,1,2,3,0,...
REQ-029 Valid deasserting in the same cycle ready rises is not a transfer; the requester is eligible again later.

Reset
REQ-030 In any state, sys_reset=1 at a clock edge returns the FSM to IDLE and clears the lock, the pointer (to 0) and the timeout counter; the in-flight byte is discarded.
REQ-031 Reset outputs: o_req_ready=0, o_send_data=0, o_send_data_en=0, o_grant=0, o_timeout_err=0.

Structure
REQ-032 Package uart_pkg holds the FSM state enum and the NUM_REQ, DATA_W and BUSY_TIMEOUT defaults.
REQ-033 Sub-module uart_rr_arbiter: combinational round-robin one-hot select from a request mask and a pointer.

Verification
REQ-034 Single requester 1 sends 0x5A with last=1 -> ready[1] for 1 cycle; send_en 1 cycle later with data 0x5A; grant=0010 until busy falls, then 0.
REQ-035 All 4 valid, last=1, data 0x10..0x13 -> send order 0x10,0x11,0x12,0x13; exactly one send_en per busy period.
REQ-036 Requester 2 sends 0xA1 (last=0) then 0xA2 (last=1) while requester 0 is valid -> 0xA1, 0xA2 are sent before requester 0's byte.
REQ-037 Busy held 0 after send_en -> o_timeout_err pulses 16 cycles after WAIT_BUSY entry; FSM returns to IDLE; next byte is accepted.
REQ-038 sys_reset asserted during WAIT_DONE with the lock set -> all outputs are 0 next cycle; after release, requester 0 is served first.
